// File: rtl/button_debouncer.sv
// Debounces a raw asynchronous level: synchronizes it, then accepts a new level only
// after it has differed from the current output for STABLE_CYCLES consecutive cycles.
module button_debouncer #(
   parameter int unsigned STABLE_CYCLES = 500000,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter logic        INIT_LEVEL    = 1'b0
) (
   input  logic slow_clk,
   input  logic reset,
   input  logic signal_in,
   output logic signal_out,
   output logic is_rising_out,
   output logic is_falling_out
);

   localparam int unsigned    CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_d;
   logic                   out_d;
   logic                   rise_d;
   logic                   fall_d;

   assign s = sync_q[SYNC_STAGES-1];

   // Input synchronizer; the only logic that samples signal_in.
   always_ff @(posedge slow_clk) begin
      if (!reset) begin
         sync_q <= {SYNC_STAGES{INIT_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
      end
   end

   // Counter, debounced level and edge pulses.
   always_ff @(posedge slow_clk) begin
      if (!reset) begin
         cnt            <= '0;
         signal_out     <= INIT_LEVEL;
         is_rising_out  <= 1'b0;
         is_falling_out <= 1'b0;
      end else begin
         cnt            <= cnt_d;
         signal_out     <= out_d;
         is_rising_out  <= rise_d;
         is_falling_out <= fall_d;
      end
   end

   // A match clears the run; the last mismatch cycle commits the new level.
   always_comb begin
      cnt_d  = '0;
      out_d  = signal_out;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s != signal_out) begin
         if (cnt == CNT_LAST) begin
            out_d  = s;
            rise_d = s;
            fall_d = ~s;
         end else begin
            cnt_d = cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed check of button_debouncer with STABLE_CYCLES=4, SYNC_STAGES=2, INIT_LEVEL=0.
module tb_button_debouncer;

   typedef struct packed {
      logic rst_n;
      logic sig;
      logic out;
      logic rise;
      logic fall;
   } vec_t;

   localparam int unsigned N_VEC = 27;

   logic slow_clk = 1'b0;
   logic reset;
   logic signal_in;
   logic signal_out;
   logic is_rising_out;
   logic is_falling_out;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_no  = 0;

   vec_t vecs [N_VEC];

   button_debouncer #(
      .STABLE_CYCLES(4),
      .SYNC_STAGES  (2),
      .INIT_LEVEL   (1'b0)
   ) dut (
      .slow_clk      (slow_clk),
      .reset         (reset),
      .signal_in     (signal_in),
      .signal_out    (signal_out),
      .is_rising_out (is_rising_out),
      .is_falling_out(is_falling_out)
   );

   always #5 slow_clk = ~slow_clk;

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_no, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock once, then compare on the falling edge.
   task automatic step(input logic rst_n, input logic sig,
                       input logic e_out, input logic e_rise, input logic e_fall);
      reset     = rst_n;
      signal_in = sig;
      @(posedge slow_clk);
      @(negedge slow_clk);
      edge_no++;
      check_bit("signal_out",     signal_out,     e_out);
      check_bit("is_rising_out",  is_rising_out,  e_rise);
      check_bit("is_falling_out", is_falling_out, e_fall);
   endtask

   initial begin
      logic [4:0] bounce;
      vecs = '{
         // reset held with input high
         '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
         // release, idle low
         '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
         // clean step to 1: commit on the 6th edge
         '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
         // three-cycle low glitch is rejected
         '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
         // held low: single falling pulse
         '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
         '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0}
      };

      for (int i = 0; i < int'(N_VEC); i++) begin
         step(vecs[i].rst_n, vecs[i].sig, vecs[i].out, vecs[i].rise, vecs[i].fall);
      end

      // Bounce 1,0,1,0,1 then steady 1: one rising pulse 6 edges after the last change.
      bounce = 5'b10101;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, bounce[i], 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

      // Pending fall reaches cnt=2, then reset aborts it without a pulse.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      n_checks++;
      if (dut.cnt !== 3'd2) begin
         n_fail++;
         $display("FAIL cnt_before_reset at edge %0d: got %0d, expected 2", edge_no, dut.cnt);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dut.cnt !== 3'd0) begin
         n_fail++;
         $display("FAIL cnt_after_reset at edge %0d: got %0d, expected 0", edge_no, dut.cnt);
      end

      // Normal operation resumes with full latency after release.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_no);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have a parameter STABLE_CYCLES, default 500000, giving the number of consecutive mismatch cycles required to accept a new level (10 ms at 50 MHz); legal range 1 to 2^24.
REQ-002 The block SHALL have a parameter SYNC_STAGES, default 2, giving the input synchronizer depth; legal minimum 2.
REQ-003 The block SHALL have a parameter INIT_LEVEL, default 1'b0, giving the level loaded into all state on reset.
REQ-004 The block SHALL have port slow_clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port signal_in, input, 1 bit: raw asynchronous button or level input.
REQ-007 The block SHALL have port signal_out, output, 1 bit: debounced level, registered.
REQ-008 The block SHALL have port is_rising_out, output, 1 bit: one-cycle pulse when signal_out changes 0->1, registered.
REQ-009 The block SHALL have port is_falling_out, output, 1 bit: one-cycle pulse when signal_out changes 1->0, registered.

Function
REQ-010 signal_in SHALL pass through a SYNC_STAGES-deep flip-flop chain; the last stage is "s", and no other logic SHALL sample signal_in.
REQ-011 The block SHALL hold a mismatch counter cnt of width clog2(STABLE_CYCLES+1) bits.
REQ-012 In a cycle where s == signal_out, cnt SHALL clear to 0 and signal_out SHALL hold.
REQ-013 In a cycle where s != signal_out and cnt < STABLE_CYCLES-1, cnt SHALL increment by 1 and signal_out SHALL hold.
REQ-014 In a cycle where s != signal_out and cnt == STABLE_CYCLES-1, signal_out SHALL take s and cnt SHALL clear to 0 on that same edge.
REQ-015 Any mismatch run shorter than STABLE_CYCLES cycles (glitch or bounce) SHALL leave signal_out unchanged and restart the count from 0.
REQ-016 is_rising_out SHALL be 1 for exactly the one cycle following the edge where signal_out goes 0->1, and 0 otherwise.
REQ-017 is_falling_out SHALL be 1 for exactly the one cycle following the edge where signal_out goes 1->0, and 0 otherwise.
REQ-018 is_rising_out and is_falling_out SHALL never be 1 in the same cycle.
REQ-019 Latency: a clean input step SHALL appear on signal_out and the matching pulse SHALL assert SYNC_STAGES+STABLE_CYCLES rising edges after the step.
REQ-020 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-021 With STABLE_CYCLES=1, signal_out SHALL follow s with one cycle of delay and a pulse SHALL accompany every change.
REQ-022 The block SHALL contain no combinational path from input to output and no latches.

Reset
REQ-023 While reset is low at a rising edge, all synchronizer stages and signal_out SHALL load INIT_LEVEL, cnt SHALL load 0, and both pulse outputs SHALL load 0.
REQ-024 Reset SHALL take priority over all other behaviour, SHALL abort any count in progress, and SHALL NOT generate a pulse even if the reset changes signal_out.
REQ-025 After reset is released, the first pulse SHALL require a full SYNC_STAGES+STABLE_CYCLES stable run.
REQ-026 The block SHALL use no asynchronous reset; initial values are not relied upon.

Verification
All scenarios use STABLE_CYCLES=4, SYNC_STAGES=2, INIT_LEVEL=0.
REQ-027 Hold reset low for 3 cycles with signal_in=1 -> signal_out=0, both pulses 0, and no pulse on release.
REQ-028 After reset, step signal_in 0->1 and hold -> signal_out=1 and is_rising_out=1 exactly at edge 6, and is_rising_out=0 at edge 7.
REQ-029 With signal_out=1, drive signal_in 0 for 3 cycles then 1 -> signal_out stays 1 and no pulse occurs.
REQ-030 Bounce pattern 1,0,1,0,1 then steady 1 -> exactly one rising pulse, 6 edges after the last transition.
REQ-031 With signal_out=1, drive signal_in=0 and hold -> is_falling_out=1 for exactly one cycle and signal_out=0.
REQ-032 Assert reset at cnt=2 during a pending change -> cnt=0, signal_out=0, no pulse, then normal operation resumes.
